// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS, ARB_DONE} arb_state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA  = 1;
  localparam int REQ_DBG   = 2;

  localparam int CNT_W = 8;

  // A single requester still needs a 1-bit index/pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin picker: first requesting index at or after ptr, wrapping modulo NREQ.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int PW   = ptr_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   idx
);

  always_comb begin
    int j;
    j     = 0;
    valid = 1'b0;
    idx   = '0;
    // Scan from the farthest offset down so the nearest requester overwrites last.
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        valid = 1'b1;
        idx   = PW'(j);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the single-ported unified memory between fetch, data and debug.
// state      | meaning
// ARB_IDLE   | waiting for a request; winner and its command are latched on exit
// ARB_ACCESS | mem_req high from latched command; leaves on mem_ready or timeout
// ARB_DONE   | one-cycle ack to the owner with rdata/err; rr pointer advances
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  input  logic [NREQ*4-1:0] be,
  output logic [NREQ-1:0]   ack,
  output logic [DW-1:0]     rdata,
  output logic              err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ready
);

  localparam int PW = ptr_width(NREQ);

  arb_state_t       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q;
  logic [PW-1:0]    owner_q;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;
  logic             lat_we_q;
  logic [AW-1:0]    lat_addr_q;
  logic [DW-1:0]    lat_wdata_q;
  logic [3:0]       lat_be_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    rdata_q;
  logic             err_q;
  logic             timeout_hit;

  mem_port_arbiter_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Counter is compared before its increment, so ACCESS lasts exactly TIMEOUT cycles.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (pick_valid) state_d = ARB_ACCESS;
      ARB_ACCESS: if (mem_ready || timeout_hit) state_d = ARB_DONE;
      ARB_DONE:   state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            owner_q     <= pick_idx;
            lat_we_q    <= we[pick_idx];
            lat_addr_q  <= addr[pick_idx*AW +: AW];
            lat_wdata_q <= wdata[pick_idx*DW +: DW];
            lat_be_q    <= be[pick_idx*4 +: 4];
          end
        end
        ARB_ACCESS: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (mem_ready) begin
            rdata_q <= lat_we_q ? '0 : mem_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        ARB_DONE: begin
          cnt_q    <= '0;
          err_q    <= 1'b0;
          rr_ptr_q <= (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ARB_DONE) ack[owner_q] = 1'b1;
  end

  assign err       = (state_q == ARB_DONE) && err_q;
  assign rdata     = rdata_q;
  assign busy      = (state_q == ARB_ACCESS) || (state_q == ARB_DONE);
  assign mem_req   = (state_q == ARB_ACCESS);
  assign mem_we    = mem_req && lat_we_q;
  assign mem_addr  = lat_addr_q;
  assign mem_wdata = lat_wdata_q;
  assign mem_be    = lat_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus timeout, req-drop and async-reset sequences.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, we;
  logic [95:0] addr, wdata;
  logic [11:0] be;
  logic [2:0]  ack;
  logic [31:0] rdata;
  logic        err, busy, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

  mem_port_arbiter #(.NREQ(3), .AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .ack(ack), .rdata(rdata), .err(err), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] a_c  [3] = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0300};
  logic [31:0] wd_c [3] = '{32'h1111_1111, 32'h1234_5678, 32'h3333_3333};
  logic [3:0]  be_c [3] = '{4'h1, 4'hF, 4'h3};

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  we;
    int          wait_cyc;
    logic [31:0] mrd;
    int          own;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_bus();
    addr  = {a_c[2], a_c[1], a_c[0]};
    wdata = {wd_c[2], wd_c[1], wd_c[0]};
    be    = {be_c[2], be_c[1], be_c[0]};
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int          lat;
    logic        exp_we;
    logic [31:0] exp_rd;
    lat    = -1;
    exp_we = v.we[v.own];
    exp_rd = exp_we ? 32'h0 : v.mrd;
    req = v.req;
    we  = v.we;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_req) begin
        lat = i;
        break;
      end
    end
    chk({tag, " latency"}, lat, 0);
    chk({tag, " mem_addr"}, mem_addr, a_c[v.own]);
    chk({tag, " mem_we"}, mem_we, exp_we);
    chk({tag, " mem_wdata"}, mem_wdata, wd_c[v.own]);
    chk({tag, " mem_be"}, mem_be, be_c[v.own]);
    chk({tag, " busy"}, busy, 1);
    for (int i = 0; i < v.wait_cyc; i++) begin
      @(negedge clk);
      chk({tag, " addr_held"}, {mem_req, mem_addr}, {1'b1, a_c[v.own]});
    end
    mem_ready = 1'b1;
    mem_rdata = v.mrd;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = '0;
    chk({tag, " ack"}, ack, 3'b001 << v.own);
    chk({tag, " rdata"}, rdata, exp_rd);
    chk({tag, " err"}, err, 0);
    chk({tag, " mem_req_done"}, mem_req, 0);
    req = '0;
    @(negedge clk);
    chk({tag, " ack_one_cycle"}, ack, 0);
    chk({tag, " idle_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   hi;
    logic got;
    vecs[0] = '{3'b001, 3'b000, 2, 32'hDEAD_BEEF, REQ_FETCH};
    vecs[1] = '{3'b010, 3'b010, 1, 32'hCAFE_F00D, REQ_DATA};
    vecs[2] = '{3'b111, 3'b000, 0, 32'h0000_000A, REQ_DBG};
    vecs[3] = '{3'b111, 3'b000, 0, 32'h0000_000B, REQ_FETCH};
    vecs[4] = '{3'b111, 3'b000, 0, 32'h0000_000C, REQ_DATA};
    vecs[5] = '{3'b011, 3'b000, 0, 32'h0000_000D, REQ_FETCH};
    vecs[6] = '{3'b101, 3'b000, 0, 32'h0000_000E, REQ_DBG};
    vecs[7] = '{3'b110, 3'b110, 0, 32'h0000_000F, REQ_DATA};
    vecs[8] = '{3'b001, 3'b000, 3, 32'h0000_0010, REQ_FETCH};

    rst_n = 1'b0;
    req = '0; we = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    drive_bus();
    repeat (2) @(negedge clk);
    chk("reset ack", ack, 0);
    chk("reset err", err, 0);
    chk("reset busy", busy, 0);
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 9; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

    // Timeout against a memory that never answers.
    req = 3'b001; we = '0;
    hi = 0; got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req) hi++;
      else if (ack != 0) begin
        got = 1'b1;
        break;
      end
    end
    chk("timeout mem_req_cycles", hi, 15);
    chk("timeout ack", ack, 3'b001);
    chk("timeout err", err, 1);
    chk("timeout rdata", rdata, 0);
    chk("timeout completed", got, 1);
    req = '0;
    @(negedge clk);
    run_vec('{3'b010, 3'b000, 0, 32'h4444_4444, REQ_DATA}, "after_timeout");

    // Owner drops req and changes addr mid-access.
    req = 3'b100; we = '0;
    @(negedge clk);
    chk("drop mem_req", mem_req, 1);
    req = '0;
    addr[95:64] = 32'h0000_0BAD;
    repeat (3) begin
      @(negedge clk);
      chk("drop mem_addr", mem_addr, 32'h0000_0300);
    end
    mem_ready = 1'b1; mem_rdata = 32'h0000_0055;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    chk("drop ack", ack, 3'b100);
    chk("drop rdata", rdata, 32'h0000_0055);
    drive_bus();
    @(negedge clk);

    // Leave the rr pointer at 2, then reset in the middle of an access.
    run_vec('{3'b010, 3'b000, 0, 32'h6666_6666, REQ_DATA}, "pre_reset");
    req = 3'b001;
    @(negedge clk);
    chk("rst mem_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    req = '0;
    #1;
    chk("rst mem_req_now", mem_req, 0);
    chk("rst busy_now", busy, 0);
    repeat (2) begin
      @(negedge clk);
      chk("rst no_ack", ack, 0);
    end
    rst_n = 1'b1;
    run_vec('{3'b110, 3'b000, 1, 32'h7777_7777, REQ_DATA}, "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
